reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Operand-wait buffer directly downstream of operand read. Accepts dispatched ops whose
//  sources are {data, tag} pairs (tag 0 = value present, nonzero = pending ROB tag).
//  Snoops the CDB to capture pending values. Issues ready ops to one execution unit.
// PARAMETERS
//  DEPTH   4   number of entries (>=2)
//  DATA_W  16  operand/result width
//  TAG_W   4   ROB tag width; tag 0 reserved as "no dependency"
//  OP_W    4   opcode width carried opaquely
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous active-low reset
//  flush           in   1       sync squash of all entries (mispredict/exception)
//  disp_valid      in   1       dispatch request
//  disp_ready      out  1       free entry exists
//  disp_op         in   OP_W    opcode
//  disp_dst_tag    in   TAG_W   ROB tag of result
//  disp_s1_data    in   DATA_W  src1 value (valid when disp_s1_tag==0)
//  disp_s1_tag     in   TAG_W   src1 pending tag
//  disp_s2_data    in   DATA_W  src2 value
//  disp_s2_tag     in   TAG_W   src2 pending tag
//  cdb_valid       in   1       broadcast valid
//  cdb_tag         in   TAG_W   broadcast ROB tag (nonzero)
//  cdb_data        in   DATA_W  broadcast value
//  iss_valid       out  1       ready op presented
//  iss_ready       in   1       execution unit accepts
//  iss_op          out  OP_W    issued opcode
//  iss_dst_tag     out  TAG_W   issued destination tag
//  iss_a, iss_b    out  DATA_W  issued operands
//  occupancy       out  $clog2(DEPTH+1)  valid-entry count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all entries invalid; disp_ready=1, iss_valid=0,
//    iss_* =0, occupancy=0. Entry payload need not be cleared.
//  - disp_ready = !(all entries valid), from registered state only; an entry freed by
//    issue this cycle is reusable next cycle.
//  - Dispatch fires on disp_valid&&disp_ready&&!flush: writes lowest-index free entry.
//    Dispatch-time bypass: if cdb_valid && cdb_tag==disp_sN_tag && disp_sN_tag!=0, the
//    entry stores cdb_data with tag 0 for that source.
//  - Wakeup: every valid entry with sN_tag==cdb_tag (nonzero) and cdb_valid captures
//    cdb_data, sets sN_tag=0 at the clock edge. Both sources may wake in one cycle.
//  - Ready = valid && s1_tag==0 && s2_tag==0 (registered). Woken entries become
//    issuable the cycle after the broadcast; a fully-ready dispatch issues >=1 cycle later.
//  - Issue select: combinational over ready entries (policy below). iss_valid=|ready;
//    iss_* reflect selected entry, forced 0 when iss_valid=0. Entry invalidated on
//    iss_valid&&iss_ready. Outputs stable while iss_valid&&!iss_ready except a newly
//    ready higher-priority entry may replace the selection (no stall contract).
//  - Simultaneous dispatch+issue: both take effect; occupancy unchanged.
//  - flush: at the edge all entries invalid; dispatch and issue in that cycle dropped
//    (iss handshake ignored); flush has priority over everything except reset.
//  - occupancy counts valid entries after the edge, never exceeds DEPTH.
//  - Dispatch with disp_valid while full: no write, no error; upstream must hold.
// CONFIGURATION
//  RS_OLDEST_FIRST_EN defined: each entry keeps age ($clog2(DEPTH) bits); dispatched
//    entry age=0, all other valid entries increment (saturate DEPTH-1); issue picks
//    ready entry with greatest age, ties -> lowest index.
//  Undefined: issue picks lowest-index ready entry; no age state.
// TESTING
//  1 Reset, then dispatch op=3 dst=5 s1=(0x0011,0) s2=(0x0022,0) -> next cycle
//    iss_valid=1, iss_a=0x0011, iss_b=0x0022, iss_dst_tag=5; iss_ready=1 -> occupancy 0.
//  2 Dispatch s1_tag=7 pending; cdb_valid tag=7 data=0xBEEF two cycles later ->
//    iss_valid rises cycle after broadcast with iss_a=0xBEEF.
//  3 Dispatch s2_tag=9 same cycle as cdb tag=9 data=0x1234 -> bypass; issues next
//    cycle with iss_b=0x1234.
//  4 Fill DEPTH entries all pending -> disp_ready=0, extra disp_valid ignored;
//    one issue -> disp_ready=1 following cycle.
//  5 Entries pending, flush=1 with disp_valid=1 -> occupancy=0, iss_valid=0, nothing
//    written; later CDB broadcast causes no issue.
//  6 RS_OLDEST_FIRST_EN: dispatch A(tag 3 pending) to idx0, B ready to idx1, wake A ->
//    with macro A (older) issues before a later-dispatched ready C in free idx;
//    without macro lowest index wins.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-wait reservation station with CDB snoop and single issue port (optional RS_OLDEST_FIRST_EN)
module reservation_station #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OP_W-1:0]              disp_op,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic [DATA_W-1:0]            disp_s1_data,
    input  logic [TAG_W-1:0]             disp_s1_tag,
    input  logic [DATA_W-1:0]            disp_s2_data,
    input  logic [TAG_W-1:0]             disp_s2_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_op,
    output logic [TAG_W-1:0]             iss_dst_tag,
    output logic [DATA_W-1:0]            iss_a,
    output logic [DATA_W-1:0]            iss_b,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  ready;
    logic [OP_W-1:0]   e_op      [DEPTH];
    logic [TAG_W-1:0]  e_dst     [DEPTH];
    logic [DATA_W-1:0] e_s1_data [DEPTH];
    logic [TAG_W-1:0]  e_s1_tag  [DEPTH];
    logic [DATA_W-1:0] e_s2_data [DEPTH];
    logic [TAG_W-1:0]  e_s2_tag  [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
    logic [IDX_W-1:0]  age       [DEPTH];
    logic [IDX_W-1:0]  best_age;
`endif

    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic              disp_fire;
    logic              iss_fire;
    logic              cdb_hit;
    logic [OCC_W-1:0]  occ_count;

    // A CDB broadcast only counts when it carries a real (nonzero) tag
    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign disp_ready = ~&valid;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign iss_fire   = iss_valid && iss_ready && !flush;

    // Entry is ready once both sources hold values
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid[i] && (e_s1_tag[i] == '0) && (e_s2_tag[i] == '0);
        end
    end

    // Lowest-index free entry receives the next dispatch
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Issue select: oldest ready entry (ties to lowest index) or lowest-index ready entry
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!sel_found || (age[i] > best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
`else
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`endif
    end

    // Issue outputs follow the selected entry and are zeroed when nothing is ready
    always_comb begin
        iss_valid   = sel_found;
        iss_op      = sel_found ? e_op[sel_idx]      : '0;
        iss_dst_tag = sel_found ? e_dst[sel_idx]     : '0;
        iss_a       = sel_found ? e_s1_data[sel_idx] : '0;
        iss_b       = sel_found ? e_s2_data[sel_idx] : '0;
    end

    // Population count of valid entries
    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                occ_count = occ_count + OCC_W'(1);
            end
        end
    end
    assign occupancy = occ_count;

    // Valid bits (and ages): flush squashes everything, otherwise issue frees and dispatch fills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
`endif
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (iss_fire) begin
                valid[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                valid[free_idx] <= 1'b1;
            end
`ifdef RS_OLDEST_FIRST_EN
            if (disp_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (IDX_W'(i) == free_idx) begin
                        age[i] <= '0;
                    end else if (valid[i] && (age[i] != IDX_W'(DEPTH-1))) begin
                        age[i] <= age[i] + IDX_W'(1);
                    end
                end
            end
`endif
        end
    end

    // Payload: dispatch write with CDB bypass, CDB wakeup of waiting sources
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && (IDX_W'(i) == free_idx)) begin
                e_op[i]  <= disp_op;
                e_dst[i] <= disp_dst_tag;
                if (cdb_hit && (cdb_tag == disp_s1_tag)) begin
                    e_s1_data[i] <= cdb_data;
                    e_s1_tag[i]  <= '0;
                end else begin
                    e_s1_data[i] <= disp_s1_data;
                    e_s1_tag[i]  <= disp_s1_tag;
                end
                if (cdb_hit && (cdb_tag == disp_s2_tag)) begin
                    e_s2_data[i] <= cdb_data;
                    e_s2_tag[i]  <= '0;
                end else begin
                    e_s2_data[i] <= disp_s2_data;
                    e_s2_tag[i]  <= disp_s2_tag;
                end
            end else if (valid[i] && cdb_hit) begin
                if (e_s1_tag[i] == cdb_tag) begin
                    e_s1_data[i] <= cdb_data;
                    e_s1_tag[i]  <= '0;
                end
                if (e_s2_tag[i] == cdb_tag) begin
                    e_s2_data[i] <= cdb_data;
                    e_s2_tag[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard testbench for reservation_station
module tb_reservation_station;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  dst;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_op;
    logic [3:0]  disp_dst_tag;
    logic [15:0] disp_s1_data;
    logic [3:0]  disp_s1_tag;
    logic [15:0] disp_s2_data;
    logic [3:0]  disp_s2_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_op;
    logic [3:0]  iss_dst_tag;
    logic [15:0] iss_a;
    logic [15:0] iss_b;
    logic [2:0]  occupancy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    reservation_station dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_op      (disp_op),
        .disp_dst_tag (disp_dst_tag),
        .disp_s1_data (disp_s1_data),
        .disp_s1_tag  (disp_s1_tag),
        .disp_s2_data (disp_s2_data),
        .disp_s2_tag  (disp_s2_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_op       (iss_op),
        .iss_dst_tag  (iss_dst_tag),
        .iss_a        (iss_a),
        .iss_b        (iss_b),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [3:0] dst,
                              input logic [15:0] d1, input logic [3:0] t1,
                              input logic [15:0] d2, input logic [3:0] t2);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_dst_tag = dst;
        disp_s1_data = d1;
        disp_s1_tag  = t1;
        disp_s2_data = d2;
        disp_s2_tag  = t2;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [3:0] dst,
                            input logic [15:0] d1, input logic [3:0] t1,
                            input logic [15:0] d2, input logic [3:0] t2);
        drive_disp(op, dst, d1, t1, d2, t2);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
        cdb_tag   = '0;
    endtask

    // Scoreboard: every accepted issue must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {iss_op, iss_dst_tag, iss_a, iss_b}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("iss_op",  {28'h0, iss_op},      {28'h0, e.op});
                check("iss_dst", {28'h0, iss_dst_tag}, {28'h0, e.dst});
                check("iss_a",   {16'h0, iss_a},       {16'h0, e.a});
                check("iss_b",   {16'h0, iss_b},       {16'h0, e.b});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout sb_left=%0d", sb.size());
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        disp_op = '0; disp_dst_tag = '0; disp_s1_data = '0; disp_s1_tag = '0;
        disp_s2_data = '0; disp_s2_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_occ", occupancy, 0);
        check("rst_iss_a", iss_a, 0);
        rst_n = 1'b1;
        tick();

        // T1: fully ready dispatch issues the following cycle
        iss_ready = 1'b1;
        sb.push_back('{op: 4'd3, dst: 4'd5, a: 16'h0011, b: 16'h0022});
        dispatch(4'd3, 4'd5, 16'h0011, 4'd0, 16'h0022, 4'd0);
        check("t1_iss_valid", iss_valid, 1);
        check("t1_iss_a", iss_a, 16'h0011);
        check("t1_dst", iss_dst_tag, 4'd5);
        tick();
        check("t1_occ", occupancy, 0);

        // T2: pending src1 woken by broadcast two cycles later
        sb.push_back('{op: 4'd4, dst: 4'd6, a: 16'hBEEF, b: 16'h0055});
        dispatch(4'd4, 4'd6, 16'h0000, 4'd7, 16'h0055, 4'd0);
        check("t2_wait0", iss_valid, 0);
        tick();
        check("t2_wait1", iss_valid, 0);
        broadcast(4'd7, 16'hBEEF);
        check("t2_woken", iss_valid, 1);
        check("t2_iss_a", iss_a, 16'hBEEF);
        tick();

        // T3: dispatch-time bypass of src2
        sb.push_back('{op: 4'd5, dst: 4'd7, a: 16'h0066, b: 16'h1234});
        drive_disp(4'd5, 4'd7, 16'h0066, 4'd0, 16'h0000, 4'd9);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'h1234;
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
        check("t3_iss_valid", iss_valid, 1);
        check("t3_iss_b", iss_b, 16'h1234);
        tick();
        check("t3_occ", occupancy, 0);

        // T4: fill all entries with pending ops, extra dispatch ignored
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dispatch(4'(i + 1), 4'(i + 8), 16'h0000, 4'(i + 10), 16'(16'h0100 + i), 4'd0);
        end
        check("t4_full_ready", disp_ready, 0);
        check("t4_full_occ", occupancy, 4);
        dispatch(4'd15, 4'd15, 16'hDEAD, 4'd0, 16'hDEAD, 4'd0);
        check("t4_extra_occ", occupancy, 4);
        check("t4_no_issue", iss_valid, 0);
        sb.push_back('{op: 4'd1, dst: 4'd8, a: 16'hA000, b: 16'h0100});
        broadcast(4'd10, 16'hA000);
        check("t4_woken", iss_valid, 1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        check("t4_ready_again", disp_ready, 1);
        check("t4_occ3", occupancy, 3);

        // T5: flush drops dispatch and a pending issue handshake
        broadcast(4'd11, 16'hB000);
        check("t5_pre_valid", iss_valid, 1);
        flush = 1'b1; iss_ready = 1'b1;
        drive_disp(4'd2, 4'd2, 16'h0001, 4'd0, 16'h0002, 4'd0);
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        check("t5_occ", occupancy, 0);
        check("t5_iss_valid", iss_valid, 0);
        broadcast(4'd12, 16'hC000);
        broadcast(4'd13, 16'hD000);
        check("t5_late_cdb", iss_valid, 0);
        check("t5_occ_late", occupancy, 0);

        // T6: issue order between an older woken op and a newer ready op in a lower index
        iss_ready = 1'b0;
        sb.push_back('{op: 4'd9, dst: 4'd1, a: 16'h0901, b: 16'h0902});
        dispatch(4'd9,  4'd1, 16'h0901, 4'd0, 16'h0902, 4'd0);
        dispatch(4'd10, 4'd2, 16'h0000, 4'd3, 16'h00A2, 4'd0);
        dispatch(4'd11, 4'd3, 16'h00B1, 4'd0, 16'h00B2, 4'd0);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        dispatch(4'd12, 4'd4, 16'h00C1, 4'd0, 16'h00C2, 4'd0);
        broadcast(4'd3, 16'hA0A1);
`ifdef RS_OLDEST_FIRST_EN
        sb.push_back('{op: 4'd10, dst: 4'd2, a: 16'hA0A1, b: 16'h00A2});
        sb.push_back('{op: 4'd11, dst: 4'd3, a: 16'h00B1, b: 16'h00B2});
        sb.push_back('{op: 4'd12, dst: 4'd4, a: 16'h00C1, b: 16'h00C2});
`else
        sb.push_back('{op: 4'd12, dst: 4'd4, a: 16'h00C1, b: 16'h00C2});
        sb.push_back('{op: 4'd10, dst: 4'd2, a: 16'hA0A1, b: 16'h00A2});
        sb.push_back('{op: 4'd11, dst: 4'd3, a: 16'h00B1, b: 16'h00B2});
`endif
        check("t6_occ3", occupancy, 3);
        iss_ready = 1'b1;
        repeat (3) tick();
        check("t6_drained", occupancy, 0);

        // T7: simultaneous dispatch and issue keep occupancy constant
        iss_ready = 1'b0;
        sb.push_back('{op: 4'd13, dst: 4'd5, a: 16'h0D01, b: 16'h0D02});
        dispatch(4'd13, 4'd5, 16'h0D01, 4'd0, 16'h0D02, 4'd0);
        check("t7_occ1", occupancy, 1);
        iss_ready = 1'b1;
        sb.push_back('{op: 4'd14, dst: 4'd6, a: 16'h0E01, b: 16'hE2E2});
        dispatch(4'd14, 4'd6, 16'h0E01, 4'd0, 16'h0000, 4'd2);
        check("t7_occ_same", occupancy, 1);
        broadcast(4'd2, 16'hE2E2);
        check("t7_woken", iss_valid, 1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            tick();
        end
        check("sb_drained", sb.size(), 0);
        check("end_occ", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
